// File: rtl/equ_search_pkg.sv
// Shared definitions for the equality key-search engine: data width,
// default table geometry and the FSM state encoding.
package equ_search_pkg;

  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_IDX_W = 3;

  // Encoding 2'd3 is unused and recovers to IDLE in the engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/equ_8bit.sv
// Combinational 8-bit equality comparator; the compare datapath of the
// key-search engine. Bitwise compare, so signed bytes need no special handling.
module equ_8bit
  import equ_search_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_r
);

  assign o_r = (i_a == i_b);

endmodule

// File: rtl/equ_search_8bit.sv
// Sequential key-search engine: a DEPTH-entry table of bytes scanned one entry
// per cycle against a latched key, with valid/ready request and response.
// Optional feature macro: MATCH_COUNT_EN (full scan, lowest index plus match
// count on rsp_count). Without it the scan stops at the first match.
module equ_search_8bit
  import equ_search_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
`ifdef MATCH_COUNT_EN
  output logic [IDX_W-1:0]  rsp_index,
  output logic [IDX_W:0]    rsp_count
`else
  output logic [IDX_W-1:0]  rsp_index
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_key;
  logic [DATA_W-1:0]  r_table [DEPTH];
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_rsp_hit;
  logic [IDX_W-1:0]   r_rsp_index;

  logic [DATA_W-1:0]  w_entry;
  logic               w_eq;
  logic               w_last;

  assign w_entry = r_table[r_idx];
  assign w_last  = (r_idx == LAST_IDX);

  equ_8bit u_equ (
    .i_a (w_entry),
    .i_b (r_key),
    .o_r (w_eq)
  );

`ifdef MATCH_COUNT_EN
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W:0]     r_cnt;
  logic               r_found;
  logic [IDX_W-1:0]   r_first_idx;
  logic [IDX_W:0]     r_rsp_count;
  logic [IDX_W:0]     w_cnt_next;

  // Running match count including the entry compared this cycle, saturating at DEPTH.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_eq && (r_cnt != DEPTH_CNT)) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  assign rsp_count = r_rsp_count;
`endif

  // Table storage: writes land at the edge in any state; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // Search FSM with index counter and registered handshake/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_key       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_index <= '0;
`ifdef MATCH_COUNT_EN
      r_cnt       <= '0;
      r_found     <= 1'b0;
      r_first_idx <= '0;
      r_rsp_count <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid) begin
            r_key       <= req_key;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= SCAN;
`ifdef MATCH_COUNT_EN
            r_cnt       <= '0;
            r_found     <= 1'b0;
            r_first_idx <= '0;
`endif
          end
        end

        SCAN: begin
`ifdef MATCH_COUNT_EN
          r_cnt <= w_cnt_next;
          if (w_eq && !r_found) begin
            r_found     <= 1'b1;
            r_first_idx <= r_idx;
          end
          if (w_last) begin
            r_state     <= DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_count <= w_cnt_next;
            r_rsp_hit   <= (w_cnt_next != '0);
            if (r_found) begin
              r_rsp_index <= r_first_idx;
            end else if (w_eq) begin
              r_rsp_index <= r_idx;
            end else begin
              r_rsp_index <= '0;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`else
          if (w_eq) begin
            r_state     <= DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= 1'b1;
            r_rsp_index <= r_idx;
          end else if (w_last) begin
            r_state     <= DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= 1'b0;
            r_rsp_index <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`endif
        end

        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_index = r_rsp_index;

endmodule

// File: tb/tb_equ_search_8bit.sv
// Directed self-checking bench for equ_search_8bit (DEPTH=8). Works with or
// without MATCH_COUNT_EN; expected latencies and counts follow the build.
module tb_equ_search_8bit;

`ifdef MATCH_COUNT_EN
  localparam bit COUNT_MODE = 1'b1;
`else
  localparam bit COUNT_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_key = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_hit;
  logic [2:0] rsp_index;
`ifdef MATCH_COUNT_EN
  logic [3:0] rsp_count;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int edges;

  always #5 clk = ~clk;

  equ_search_8bit #(.DEPTH(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
`ifdef MATCH_COUNT_EN
    .rsp_index (rsp_index),
    .rsp_count (rsp_count)
`else
    .rsp_index (rsp_index)
`endif
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic writeEntry(input logic [2:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // Present a request for one edge (the accept edge).
  task automatic applyStimulus(input logic [7:0] key);
    req_valid = 1'b1;
    req_key   = key;
    tick();
    req_valid = 1'b0;
  endtask

  // Count edges until rsp_valid, bounded so a stuck engine cannot hang the run.
  task automatic waitResponse(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic checkResponse(input string tag, input int lat, input int expLat,
                               input logic expHit, input logic [2:0] expIdx, input logic [3:0] expCnt);
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_hit"}, 32'(rsp_hit), 32'(expHit));
    checkOutput({tag, "_index"}, 32'(rsp_index), 32'(expIdx));
    checkOutput({tag, "_busy"}, 32'(req_ready), 32'd0);
`ifdef MATCH_COUNT_EN
    checkOutput({tag, "_count"}, 32'(rsp_count), 32'(expCnt));
`else
    if (expCnt > 4'd8) $display("[TB] note: count %0d out of range", expCnt);
`endif
  endtask

  task automatic releaseResponse(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, "_rel_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rel_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // 1: reset state, then search 0x00 in the cleared table
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    checkOutput("reset_rsp_index", 32'(rsp_index), 32'd0);
`ifdef MATCH_COUNT_EN
    checkOutput("reset_rsp_count", 32'(rsp_count), 32'd0);
`endif
    applyStimulus(8'h00);
    waitResponse(edges);
    checkResponse("t1", edges, COUNT_MODE ? 8 : 1, 1'b1, 3'd0, 4'd8);
    releaseResponse("t1");

    // 2: entry5 = A5, others 11
    for (int i = 0; i < 8; i++) begin
      writeEntry(3'(i), (i == 5) ? 8'hA5 : 8'h11);
    end
    applyStimulus(8'hA5);
    waitResponse(edges);
    checkResponse("t2", edges, COUNT_MODE ? 8 : 6, 1'b1, 3'd5, 4'd1);
    releaseResponse("t2");

    // 3: miss, with outputs held while rsp_ready stays low
    applyStimulus(8'h7F);
    waitResponse(edges);
    checkResponse("t3", edges, 8, 1'b0, 3'd0, 4'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("t3_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t3_hold_hit", 32'(rsp_hit), 32'd0);
      checkOutput("t3_hold_index", 32'(rsp_index), 32'd0);
      checkOutput("t3_hold_ready", 32'(req_ready), 32'd0);
    end
    releaseResponse("t3");

    // 4: two matches of a negative byte; lowest index wins
    writeEntry(3'd2, 8'h80);
    writeEntry(3'd6, 8'h80);
    applyStimulus(8'h80);
    waitResponse(edges);
    checkResponse("t4", edges, COUNT_MODE ? 8 : 3, 1'b1, 3'd2, 4'd2);
    releaseResponse("t4");

    // 5a: write entry7 = key while idx=3, ahead of the scan
    applyStimulus(8'h3C);
    repeat (3) tick();
    checkOutput("t5a_midscan_valid", 32'(rsp_valid), 32'd0);
    writeEntry(3'd7, 8'h3C);
    waitResponse(edges);
    checkResponse("t5a", edges + 4, 8, 1'b1, 3'd7, 4'd1);
    releaseResponse("t5a");

    // 5b: write entry1 = key while idx=3, behind the scan -> miss
    applyStimulus(8'h5A);
    repeat (3) tick();
    writeEntry(3'd1, 8'h5A);
    waitResponse(edges);
    checkResponse("t5b", edges + 4, 8, 1'b0, 3'd0, 4'd0);
    releaseResponse("t5b");

    // Write and request on the same edge: the search sees the new value
    wr_en     = 1'b1;
    wr_addr   = 3'd0;
    wr_data   = 8'hC3;
    req_valid = 1'b1;
    req_key   = 8'hC3;
    tick();
    wr_en     = 1'b0;
    req_valid = 1'b0;
    waitResponse(edges);
    checkResponse("same_edge", edges, COUNT_MODE ? 8 : 1, 1'b1, 3'd0, 4'd1);
    releaseResponse("same_edge");

    // 6: reset in the middle of a scan
    applyStimulus(8'h22);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_req_ready", 32'(req_ready), 32'd1);
    checkOutput("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t6_rsp_hit", 32'(rsp_hit), 32'd0);
    checkOutput("t6_rsp_index", 32'(rsp_index), 32'd0);
    tick();
    checkOutput("t6_no_late_rsp", 32'(rsp_valid), 32'd0);
    applyStimulus(8'h00);
    waitResponse(edges);
    checkResponse("t6_zero", edges, COUNT_MODE ? 8 : 1, 1'b1, 3'd0, 4'd8);
    releaseResponse("t6_zero");
    applyStimulus(8'hA5);
    waitResponse(edges);
    checkResponse("t6_cleared", edges, 8, 1'b0, 3'd0, 4'd0);
    releaseResponse("t6_cleared");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
